// File: rtl/output_queue_buffer.sv
// Router output-port flit queue: first-word-fall-through FIFO with valid/ready drain,
// occupancy flags for the switch allocator and a sticky overflow indicator.
module output_queue_buffer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PTR_W        = 2,
  parameter int unsigned AFULL_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic                  overflow_err
);

  localparam int unsigned    DEPTH    = 1 << PTR_W;
  localparam logic [PTR_W:0] CntDepth = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CntAfull = (PTR_W + 1)'(AFULL_THRESH);
  localparam logic [PTR_W:0] CntOne   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  r_overflow_err;

  logic                  w_pop;
  logic                  w_push;
  logic [PTR_W:0]        w_count_d;

  // A pop frees a slot in the same edge, so a full queue can still accept a write.
  assign w_pop  = valid_out & ready_in;
  assign w_push = wr_en & (~full | w_pop);

  always_comb begin
    w_count_d = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntOne;
      2'b01:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      r_count <= w_count_d;
      if (wr_en && !w_push) r_overflow_err <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CntDepth);
  assign almost_full  = (r_count >= CntAfull);
  assign overflow_err = r_overflow_err;
  assign valid_out    = ~empty;
  assign data_out     = valid_out ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_output_queue_buffer.sv
// Self-checking bench for output_queue_buffer: directed fill/drain, overflow, full
// push+pop, wrap/latency, async reset and a short random soak against a queue model.
module tb_output_queue_buffer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] data_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow_err;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [31:0] q[$];
  logic        m_ovf;

  output_queue_buffer #(
    .DATA_WIDTH  (32),
    .PTR_W       (2),
    .AFULL_THRESH(3)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .count       (count),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // Called at posedge+1; drives one cycle, checks pre-edge outputs and post-edge state.
  task automatic step(input logic wr, input logic [31:0] d, input logic rdy);
    logic pop;
    logic push;
    wr_en = wr; data_in = d; ready_in = rdy;
    #1;
    check("valid_out", {31'd0, valid_out}, {31'd0, q.size() != 0});
    if (q.size() != 0) check("data_out", data_out, q[0]);
    else               check("data_out_idle", data_out, 32'd0);
    pop  = rdy && (q.size() != 0);
    push = wr && ((q.size() < 4) || pop);
    @(posedge clk); #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    if (wr && !push) m_ovf = 1'b1;
    check("count",        {29'd0, count},        32'(q.size()));
    check("empty",        {31'd0, empty},        {31'd0, q.size() == 0});
    check("full",         {31'd0, full},         {31'd0, q.size() == 4});
    check("almost_full",  {31'd0, almost_full},  {31'd0, q.size() >= 3});
    check("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
  endtask

  task automatic do_reset();
    rst = 1'b0; wr_en = 1'b0; data_in = '0; ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); m_ovf = 1'b0;
    check("rst_valid", {31'd0, valid_out},    32'd0);
    check("rst_data",  data_out,              32'd0);
    check("rst_empty", {31'd0, empty},        32'd1);
    check("rst_count", {29'd0, count},        32'd0);
    check("rst_ovf",   {31'd0, overflow_err}, 32'd0);
    check("rst_full",  {31'd0, full},         32'd0);
    check("rst_af",    {31'd0, almost_full},  32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_ovf = 1'b0;
    do_reset();

    // Fill with ready low, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
      if (i == 3) check("af_after_3", {31'd0, almost_full}, 32'd1);
    end
    check("full_after_4",  {31'd0, full},  32'd1);
    check("count_after_4", {29'd0, count}, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b0; ready_in = 1'b1; #1;
      check("drain_seq", data_out, 32'hA000_0000 + 32'(i));
      step(1'b0, 32'd0, 1'b1);
    end
    check("empty_after_drain", {31'd0, empty}, 32'd1);

    // Overflow drop while full and stalled.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("ovf_count",  {29'd0, count},        32'd4);
    check("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (valid_out) check("no_deadbeef", {31'd0, data_out == 32'hDEAD_BEEF}, 32'd0);
      step(1'b0, 32'd0, 1'b1);
    end
    check("ovf_still_set", {31'd0, overflow_err}, 32'd1);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    step(1'b1, 32'h5555_0001, 1'b0);
    step(1'b1, 32'h5555_0002, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_count", {29'd0, count},        32'd0);
    check("async_valid", {31'd0, valid_out},    32'd0);
    check("async_ovf",   {31'd0, overflow_err}, 32'd0);
    do_reset();

    // Full with concurrent push and pop keeps count at DEPTH.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h10 + 32'(i), 1'b1);
      check("pp_count", {29'd0, count}, 32'd4);
    end
    check("pp_no_ovf", {31'd0, overflow_err}, 32'd0);
    for (int i = 2; i < 6; i++) begin
      wr_en = 1'b0; ready_in = 1'b1; #1;
      check("pp_tail", data_out, 32'h10 + 32'(i));
      step(1'b0, 32'd0, 1'b1);
    end

    // Single writes: one-cycle latency, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h7700_0000 + 32'(i), 1'b1);
      check("lat_count1", {29'd0, count}, 32'd1);
      wr_en = 1'b0; #1;
      check("lat_data", data_out, 32'h7700_0000 + 32'(i));
      step(1'b0, 32'd0, 1'b1);
      check("lat_count0", {29'd0, count}, 32'd0);
    end

    // Random soak against the queue model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
